// File: rtl/fifo_ctrl.sv
// Stream FIFO controller in front of mem_mod. Input words are written into
// mem_mod, read back in order, and the one-cycle read latency is absorbed by
// a two-entry output buffer so both sides can move one word per cycle.
//
// Handshake rule (both streams): a word transfers on a rising clock edge
// where valid and ready are both high. Valid never depends on ready in the
// same cycle. Ready may depend on registered state only.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_ADDR   = 4,
    parameter int ADDRSIZE   = $clog2(MAX_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  mem_wr_en,
    output logic [ADDRSIZE-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDRSIZE-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [ADDRSIZE+1:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(MAX_ADDR - 1);
    localparam logic [ADDRSIZE:0]   MAX_CNT   = (ADDRSIZE + 1)'(MAX_ADDR);

    logic [ADDRSIZE-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDRSIZE-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDRSIZE:0]     mem_cnt_q, mem_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
    logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
    logic [1:0]            occ_q, occ_d;

    logic       push;
    logic       pop;
    logic       rd_issue;
    logic [2:0] occ_after;
    logic [1:0] occ_tmp;

    // Handshakes, read issue decision and next-state for all registers.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_cnt_d  = mem_cnt_q;
        inflight_d = 1'b0;
        obuf0_d    = obuf0_q;
        obuf1_d    = obuf1_q;
        occ_tmp    = occ_q;

        push = in_valid && (mem_cnt_q < MAX_CNT);
        pop  = (occ_q != 2'd0) && out_ready;

        // Buffer slots still committed after this cycle's pop; a new read is
        // allowed only if its data will have a slot to land in.
        occ_after = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_issue  = (mem_cnt_q != '0) && (occ_after < 3'd2);

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_issue) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
        end
        mem_cnt_d  = mem_cnt_q + (ADDRSIZE + 1)'(push) - (ADDRSIZE + 1)'(rd_issue);
        inflight_d = rd_issue;

        // Shift out the popped word first, then land returning read data in
        // the lowest free slot.
        if (pop) begin
            obuf0_d = obuf1_q;
            occ_tmp = occ_q - 2'd1;
        end
        if (inflight_q) begin
            if (occ_tmp == 2'd0) begin
                obuf0_d = mem_rd_data;
            end else begin
                obuf1_d = mem_rd_data;
            end
            occ_tmp = occ_tmp + 2'd1;
        end
        occ_d = occ_tmp;
    end

    // State registers; an outstanding read is dropped by clearing inflight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            obuf0_q    <= '0;
            obuf1_q    <= '0;
            occ_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            obuf0_q    <= obuf0_d;
            obuf1_q    <= obuf1_d;
            occ_q      <= occ_d;
        end
    end

    assign in_ready    = (mem_cnt_q < MAX_CNT);
    assign out_valid   = (occ_q != 2'd0);
    assign out_data    = obuf0_q;
    assign mem_wr_en   = push;
    assign mem_wr_addr = wr_ptr_q;
    assign mem_wr_data = in_data;
    assign mem_rd_en   = rd_issue;
    assign mem_rd_addr = rd_ptr_q;
    assign count       = (ADDRSIZE + 2)'(mem_cnt_q) + (ADDRSIZE + 2)'(inflight_q)
                       + (ADDRSIZE + 2)'(occ_q);
    assign empty       = (count == '0);
    assign full        = (mem_cnt_q == MAX_CNT);

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Stream FIFO controller sitting directly upstream of mem_mod; owns mem_mod's write and read ports.
- Accepts a valid/ready input stream and writes it into mem_mod. Issues reads in order and absorbs mem_mod's 1-cycle read latency in a 2-entry output buffer.
- Presents a valid/ready output stream. Sustains 1 word/cycle in and out simultaneously.

Parameters:
DATA_WIDTH, 8, word width; must match mem_mod DATA_WIDTH
MAX_ADDR, 4, mem_mod depth in words (any value >= 2, power of two not required)
ADDRSIZE, $clog2(MAX_ADDR), derived address width; not to be overridden

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  controller accepts a word this cycle
in_data  input  DATA_WIDTH  producer word
out_valid  output  1  out_data holds the oldest word
out_ready  input  1  consumer takes out_data this cycle
out_data  output  DATA_WIDTH  oldest word
mem_wr_en  output  1  to mem_mod wr_en
mem_wr_addr  output  ADDRSIZE  to mem_mod wr_addr
mem_wr_data  output  DATA_WIDTH  to mem_mod wr_data
mem_rd_en  output  1  to mem_mod rd_en
mem_rd_addr  output  ADDRSIZE  to mem_mod rd_addr
mem_rd_data  input  DATA_WIDTH  from mem_mod rd_data, valid the cycle after mem_rd_en
count  output  ADDRSIZE+2  total words held, range 0..MAX_ADDR+2
empty  output  1  count == 0
full  output  1  mem_cnt == MAX_ADDR (equals !in_ready)

Behaviour:
- State registers:
  - wr_ptr, rd_ptr: ADDRSIZE bits.
  - mem_cnt: 0..MAX_ADDR. Counts words written to mem_mod but not yet read-issued.
  - inflight: 1 bit. A read was issued last cycle.
  - buf[0..1] and buf_occ (0..2): output buffer, buf[0] is the oldest.
- Reset (rst_n low, asynchronous):
  - All of the above clear to 0.
  - Outputs: out_valid=0, out_data=0, mem_wr_en=0, mem_rd_en=0, count=0, empty=1, full=0, in_ready=1.
  - mem_mod contents are not cleared. An in-flight read is discarded.
- Push:
  - in_ready = (mem_cnt < MAX_ADDR).
  - mem_wr_en = in_valid & in_ready, combinational; mem_wr_addr = wr_ptr; mem_wr_data = in_data.
  - On push, wr_ptr advances.
- Pointer wrap: wr_ptr and rd_ptr go MAX_ADDR-1 -> 0. Never reach MAX_ADDR.
- Pop:
  - pop = out_valid & out_ready; out_valid = (buf_occ != 0); out_data = buf[0].
  - On pop, buf[1] shifts to buf[0].
- Read issue:
  - mem_rd_en = (mem_cnt != 0) & ((buf_occ + inflight - pop) < 2); mem_rd_addr = rd_ptr.
  - Uses registered mem_cnt only, so a word written at edge E is readable at the earliest by a read issued in the cycle after E. No same-address read/write hazard.
  - On issue, rd_ptr advances and inflight is set next cycle; otherwise inflight clears.
- Capture: when inflight=1, mem_rd_data is written into the first free buf slot after any pop shift. Overflow is impossible by the issue rule.
- mem_cnt next = mem_cnt + push - mem_rd_en. Simultaneous push and issue leaves it unchanged.
- count = mem_cnt + inflight + buf_occ, registered-consistent each cycle.
- Latency: word accepted at edge E0 -> mem_rd_en in cycle E0..E1 -> captured at E2 -> out_valid high after E2 (2 cycles), given an empty FIFO and free buffer.
- Full: in_ready=0 and in_valid is ignored; no write, no pointer change. Capacity is MAX_ADDR+2 words total.
- Empty: out_valid=0; out_ready is ignored.
- Backpressure: with out_ready low, buf fills to 2, reads stop, and mem_cnt fills to MAX_ADDR. No word is lost or duplicated.
- Order: strict FIFO across all wrap-arounds.

Test Plan:
- Reset: hold rst_n=0 mid-stream with 3 words held -> count=0, empty=1, in_ready=1, out_valid=0 immediately (async). After release, a push of 0x11 emerges first.
- Latency: empty FIFO, push 128 at edge E0 -> mem_rd_en=1 with mem_rd_addr=0 in the next cycle, out_valid=1 with out_data=128 after E2.
- Fill: out_ready=0, push 128, 56, 74, 200, 17, 99 -> count reaches 6 and full=1 after the 4th memory-resident word. A 7th push is not accepted (mem_wr_en=0). Drain yields 128, 56, 74, 200, 17, 99 in order.
- Throughput: in_valid=1 and out_ready=1 continuously for 20 words, values 0..19 -> after the 2-cycle fill latency, one word per cycle out, in order. count stays at 3 or below, and pointers wrap 3 -> 0 five times.
- Random backpressure: random in_valid/out_ready for 200 cycles -> scoreboard matches exactly, count is never negative, and count never exceeds 6.
- Non-power-of-two: MAX_ADDR=3 with 10 sequential words -> addresses cycle 0, 1, 2, 0 and data order is preserved.
